// File: rtl/cursor_pkg.sv
// Shared widths and default limits for the cursor tracker.
// Pure constants; no logic, no latency.
// No flow control.
package cursor_pkg;

    localparam int COORD_W         = 7;
    localparam int CNT_W           = 16;

    localparam int X_MAX_DEFAULT   = 99;
    localparam int Y_MAX_DEFAULT   = 99;
    localparam int CNT_MAX_DEFAULT = 9999;

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes one raw button, debounces it and emits a rise pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles; pulse is registered.
// No backpressure: the pulse is a single cycle and is never held.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;

    // A level flip needs DEBOUNCE_CYCLES consecutive differing samples; any agreement restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        rise_d = level_d & ~level_q;
    end

    // Synchronizer, stability counter, debounced level and rise pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/cursor_tracker.sv
// Moves an X/Y cursor from five debounced push buttons and counts moves.
// Latency: 1 cycle from press pulse to registered outputs.
// No backpressure: every accepted press is applied on the cycle it arrives.
module cursor_tracker
    import cursor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int X_MAX           = X_MAX_DEFAULT,
    parameter int Y_MAX           = Y_MAX_DEFAULT,
    parameter int CNT_MAX         = CNT_MAX_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_right,
    input  logic               btn_left,
    input  logic               btn_center,
    output logic [COORD_W-1:0] X,
    output logic [COORD_W-1:0] Y,
    output logic [CNT_W-1:0]   bcd,
    output logic               moved
);

    localparam logic [COORD_W-1:0] XM = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] YM = COORD_W'(Y_MAX);
    localparam logic [CNT_W-1:0]   CM = CNT_W'(CNT_MAX);

    // Bit order: 0 up, 1 down, 2 right, 3 left, 4 center.
    logic [4:0] raw;
    logic [4:0] lvl;
    logic [4:0] press;

    assign raw = {btn_center, btn_left, btn_right, btn_down, btn_up};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw_i  (raw[i]),
            .level_o(lvl[i]),
            .rise_o (press[i])
        );
    end

    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               moved_q, moved_d;
    logic               x_inc, x_dec, y_inc, y_dec;

    // Opposing presses cancel; center wins over everything and is not a move.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        moved_d = 1'b0;
        x_inc   = press[2] & ~press[3];
        x_dec   = press[3] & ~press[2];
        y_inc   = press[0] & ~press[1];
        y_dec   = press[1] & ~press[0];
        if (press[4]) begin
            x_d   = '0;
            y_d   = '0;
            cnt_d = '0;
        end else begin
            if (x_inc) x_d = (x_q == XM) ? '0 : x_q + COORD_W'(1);
            if (x_dec) x_d = (x_q == '0) ? XM : x_q - COORD_W'(1);
            if (y_inc) y_d = (y_q == YM) ? '0 : y_q + COORD_W'(1);
            if (y_dec) y_d = (y_q == '0) ? YM : y_q - COORD_W'(1);
            if (x_inc | x_dec | y_inc | y_dec) begin
                moved_d = 1'b1;
                cnt_d   = (cnt_q == CM) ? cnt_q : cnt_q + CNT_W'(1);
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            moved_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            moved_q <= moved_d;
        end
    end

    assign X     = x_q;
    assign Y     = y_q;
    assign bcd   = cnt_q;
    assign moved = moved_q;

    logic unused_lvl;
    assign unused_lvl = ^lvl;

endmodule

// File: tb/tb_cursor_tracker.sv
module tb_cursor_tracker;

    localparam int DB = 4;
    localparam int XM = 99;
    localparam int YM = 99;
    localparam int CM = 150;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_up, btn_down, btn_right, btn_left, btn_center;
    logic [6:0]  X, Y;
    logic [15:0] bcd;
    logic        moved;

    int total = 0;
    int bad   = 0;

    // Reference state: cursor position and move count.
    int ex = 0, ey = 0, en = 0;

    cursor_tracker #(
        .DEBOUNCE_CYCLES(DB),
        .X_MAX(XM),
        .Y_MAX(YM),
        .CNT_MAX(CM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_right (btn_right),
        .btn_left  (btn_left),
        .btn_center(btn_center),
        .X         (X),
        .Y         (Y),
        .bcd       (bcd),
        .moved     (moved)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".X"}, int'(X), ex);
        chk({tag, ".Y"}, int'(Y), ey);
        chk({tag, ".bcd"}, int'(bcd), en);
    endtask

    // Mask bits: 0 up, 1 down, 2 right, 3 left, 4 center.
    task automatic drive(input logic [4:0] m);
        btn_up     = m[0];
        btn_down   = m[1];
        btn_right  = m[2];
        btn_left   = m[3];
        btn_center = m[4];
    endtask

    task automatic run(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (moved) pulses++;
        end
    endtask

    // Behavioural model of one simultaneous press; returns expected move pulses.
    function automatic int model(input logic [4:0] m);
        int dx, dy;
        if (m[4]) begin
            ex = 0; ey = 0; en = 0;
            return 0;
        end
        dx = int'(m[2]) - int'(m[3]);
        dy = int'(m[0]) - int'(m[1]);
        ex = (ex + dx + XM + 1) % (XM + 1);
        ey = (ey + dy + YM + 1) % (YM + 1);
        if (dx == 0 && dy == 0) return 0;
        if (en < CM) en++;
        return 1;
    endfunction

    task automatic press(input string tag, input logic [4:0] m);
        int p1, p2, expm;
        drive(m);
        run(10, p1);
        drive(5'b0);
        run(8, p2);
        expm = model(m);
        chk({tag, ".moved"}, p1 + p2, expm);
        check_state(tag);
    endtask

    // Counts cycles from a raw edge until moved goes high, bounded.
    task automatic latency(output int k);
        k = 0;
        while (k < 30) begin
            @(posedge clk);
            #1;
            k++;
            if (moved) break;
        end
    endtask

    initial begin
        int k, p, p2;
        logic [4:0] m;

        rst_n = 1'b0;
        drive(5'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset.moved", int'(moved), 0);
        check_state("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Clean right press: raw edge to moved is 2 + 4 + 1 cycles.
        btn_right = 1'b1;
        latency(k);
        chk("lat.cycles", k, 2 + DB + 1);
        p = model(5'b00100);
        check_state("lat");
        run(5, p2);
        btn_right = 1'b0;
        run(8, p);
        chk("lat.extra_pulses", p + p2, 0);

        // Bounce every 2 cycles, then steady high.
        p2 = 0;
        for (int i = 0; i < 5; i++) begin
            btn_right = 1'b1;
            run(2, p);
            p2 += p;
            btn_right = 1'b0;
            run(2, p);
            p2 += p;
        end
        chk("bounce.pulses", p2, 0);
        btn_right = 1'b1;
        latency(k);
        chk("bounce.cycles", k, 2 + DB + 1);
        p = model(5'b00100);
        run(4, p2);
        btn_right = 1'b0;
        run(8, p);
        chk("bounce.extra_pulses", p + p2, 0);
        check_state("bounce");

        // Walk X to its top, then wrap.
        while (ex != XM) press("walkx", 5'b00100);
        press("wrapx", 5'b00100);
        chk("wrapx.zero", int'(X), 0);

        // Y wraps downward from 0.
        press("center", 5'b10000);
        press("wrapy", 5'b00010);
        chk("wrapy.top", int'(Y), YM);

        // Simultaneous presses.
        press("updown", 5'b00011);
        press("upright", 5'b00101);
        press("rightleft", 5'b01100);
        press("all4", 5'b01111);

        // Randomized presses, center kept rare.
        for (int i = 0; i < 60; i++) begin
            m = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) != 0) m[4] = 1'b0;
            press("rand", m);
        end

        // Reach saturation with left presses, then one more.
        while (en < CM) press("fill", 5'b01000);
        press("sat", 5'b01000);
        chk("sat.bcd", int'(bcd), CM);

        press("center_right", 5'b10100);

        // Reset mid-debounce with the button held through reset release.
        press("pre_rst", 5'b00101);
        btn_right = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        ex = 0; ey = 0; en = 0;
        chk("rst1.moved", int'(moved), 0);
        check_state("rst1");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(12, p);
        chk("rst1.after_pulses", p, 1);
        p = model(5'b00100);
        check_state("rst1.after");

        // Reset mid-hold, button still held after release.
        run(10, p);
        chk("hold.pulses", p, 0);
        #3;
        rst_n = 1'b0;
        #1;
        ex = 0; ey = 0; en = 0;
        chk("rst2.moved", int'(moved), 0);
        check_state("rst2");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(12, p);
        chk("rst2.after_pulses", p, 1);
        p = model(5'b00100);
        check_state("rst2.after");
        btn_right = 1'b0;
        run(8, p);
        chk("rst2.release_pulses", p, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cursor_tracker.md
CURSOR_TRACKER -- requirements
Module: cursor_tracker

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable cycles required to accept a button level change (10 ms at 100 MHz).
REQ-002 The block SHALL have parameter X_MAX, default 99, meaning the highest X coordinate.
REQ-003 The block SHALL have parameter Y_MAX, default 99, meaning the highest Y coordinate.
REQ-004 The block SHALL have parameter CNT_MAX, default 9999, meaning the move-count saturation value.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset: clk  input  1  100 MHz board clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 btn_up  input  1  raw, asynchronous push button; increments Y.
REQ-008 btn_down  input  1  raw push button; decrements Y.
REQ-009 btn_right  input  1  raw push button; increments X.
REQ-010 btn_left  input  1  raw push button; decrements X.
REQ-011 btn_center  input  1  raw push button; clears position and count.
REQ-012 X  output  7  cursor column, binary 0..X_MAX; feeds the display's X input.
REQ-013 Y  output  7  cursor row, binary 0..Y_MAX; feeds the display's Y input.
REQ-014 bcd  output  16  binary move count 0..CNT_MAX; feeds the display's bcd input.
REQ-015 moved  output  1  one-cycle pulse for each accepted move.

Function
REQ-016 The block SHALL pass each raw button through a 2-flop synchronizer before debouncing.
REQ-017 The block SHALL change a debounced level only after the synchronized input has differed from it for exactly DEBOUNCE_CYCLES consecutive cycles; any bounce SHALL restart the stability counter at 0.
REQ-018 The block SHALL generate a one-cycle press pulse on the cycle when a debounced level goes from 0 to 1; release SHALL generate no event.
REQ-019 All outputs SHALL be registered and SHALL update on the clock edge that samples a press pulse high, giving a 1-cycle press-pulse-to-output latency.
REQ-020 A right press SHALL increment X; a right press at X=X_MAX SHALL wrap X to 0.
REQ-021 A left press SHALL decrement X; a left press at X=0 SHALL wrap X to X_MAX.
REQ-022 Up and down presses SHALL act on Y with the same increment, decrement and wrap rules, bounded by Y_MAX.
REQ-023 Right and left presses in the same cycle SHALL leave X unchanged; up and down presses in the same cycle SHALL likewise leave Y unchanged.
REQ-024 An X press and a Y press in the same cycle SHALL both apply and SHALL count as one move.
REQ-025 A center press SHALL override all other presses in that cycle and SHALL set X=0, Y=0 and bcd=0 with moved=0.
REQ-026 When X or Y changes, moved SHALL pulse high and bcd SHALL increment by 1; bcd SHALL saturate at CNT_MAX, and moved SHALL still pulse while bcd is saturated.
REQ-027 A press whose effect cancels out per REQ-023 SHALL produce neither a moved pulse nor a bcd increment.
REQ-028 A button held down SHALL produce exactly one move, with no auto-repeat.

Reset
REQ-029 Asserting rst_n low SHALL immediately set X=0, Y=0, bcd=0 and moved=0, clear the synchronizers, debounced levels and stability counters, and abort any debounce in progress.
REQ-030 A button already held at reset release SHALL register one press after DEBOUNCE_CYCLES plus synchronizer delay.

Structure
REQ-031 The package cursor_pkg SHALL hold the COORD_W=7 and CNT_W=16 width constants and the default X_MAX, Y_MAX and CNT_MAX values.
REQ-032 The sub-module btn_debounce (synchronizer, stability counter, debounced level and rise pulse) SHALL be instantiated five times, with a stability-counter width of clog2(DEBOUNCE_CYCLES+1).

Verification
REQ-033 The bench SHALL use DEBOUNCE_CYCLES=4 and cover these scenarios:
REQ-034 Reset release, then one clean right press -> X=1, Y=0, bcd=1, one moved pulse, and moved arrives 2+4+1 cycles after the raw edge (2 synchronizer, 4 debounce, 1 output register).
REQ-035 Raw right input toggling every 2 cycles for 20 cycles, then steady -> no move during the bounce, and exactly one move after 4 stable cycles.
REQ-036 X=99 then right press -> X=0 and bcd+1; Y=0 then down press -> Y=99.
REQ-037 Up and down press pulses in the same cycle -> Y unchanged, no moved pulse; up and right pulses in the same cycle -> X+1, Y+1, bcd+1.
REQ-038 Preload bcd=9999 and press left -> bcd stays 9999 and moved pulses; center press together with right -> X=Y=bcd=0 and no moved pulse.
REQ-039 rst_n asserted mid-debounce and mid-hold -> outputs 0 asynchronously, and a press still held after reset release yields exactly one move.
